// File: rtl/sqr_shuffle_if.sv
// Bitstream port bundle for the stochastic squarer: qualified input bit in, qualified output bit out.
// in_valid qualifies in and out_valid qualifies out; there is no ready, so every qualified bit is consumed.
interface sqr_shuffle_if;
    logic in_valid;
    logic in;
    logic out_valid;
    logic out;

    modport master (
        output in_valid,
        output in,
        input  out_valid,
        input  out
    );

    modport slave (
        input  in_valid,
        input  in,
        output out_valid,
        output out
    );
endinterface

// File: rtl/sqr_shuffle.sv
// Stochastic-computing squarer: ANDs each input bit with an earlier bit drawn at random
// from a small shuffle buffer, so a stream of density p becomes one of density p^2.
module sqr_shuffle #(
    parameter int         BUF_DEPTH = 4,
    parameter int         IDX_W     = $clog2(BUF_DEPTH),
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    sqr_shuffle_if.slave         bus,
    output logic [0:0]           dbg_state,
    output logic [IDX_W:0]       dbg_fill_cnt,
    output logic [7:0]           dbg_lfsr,
    output logic [BUF_DEPTH-1:0] dbg_buf
);

    localparam logic [0:0]     ST_FILL   = 1'b0;
    localparam logic [0:0]     ST_RUN    = 1'b1;
    localparam logic [IDX_W:0] FILL_LAST = (IDX_W + 1)'(BUF_DEPTH - 1);

    logic [0:0]           state_q, state_d;
    logic [IDX_W:0]       fill_cnt_q, fill_cnt_d;
    logic [BUF_DEPTH-1:0] buf_q, buf_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic                 out_q, out_d;
    logic                 out_valid_q, out_valid_d;

    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     fill_idx;
    logic [7:0]           lfsr_step;

    // The slot index is taken from the LFSR value before this cycle's step.
    assign idx       = lfsr_q[IDX_W-1:0];
    assign fill_idx  = fill_cnt_q[IDX_W-1:0];
    assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        buf_d       = buf_q;
        lfsr_d      = lfsr_q;
        out_d       = 1'b0;
        out_valid_d = 1'b0;

        if (clr) begin
            // Restart drops any bit offered this cycle; old slots are overwritten during FILL.
            state_d    = ST_FILL;
            fill_cnt_d = '0;
            lfsr_d     = SEED;
        end else if (bus.in_valid) begin
            if (state_q == ST_FILL) begin
                buf_d[fill_idx] = bus.in;
                fill_cnt_d      = fill_cnt_q + 1'b1;
                if (fill_cnt_q == FILL_LAST) begin
                    state_d = ST_RUN;
                end
            end else begin
                out_d       = bus.in & buf_q[idx];
                out_valid_d = 1'b1;
                buf_d[idx]  = bus.in;
                lfsr_d      = lfsr_step;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            fill_cnt_q  <= '0;
            buf_q       <= '0;
            lfsr_q      <= SEED;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            buf_q       <= buf_d;
            lfsr_q      <= lfsr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

    assign dbg_state    = state_q;
    assign dbg_fill_cnt = fill_cnt_q;
    assign dbg_lfsr     = lfsr_q;
    assign dbg_buf      = buf_q;

endmodule
